multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style multi-cycle controller for the 8-bit accumulator CPU datapath.
- Consumes the datapath status buses (IR opcode nibble, DI latch, CZN flags) and drives every datapath control strobe and mux select.
- Sequences fetch, decode and execute for memory-reference, branch and register-ALU instructions.
- Sits directly beside the datapath; the CPU top wires the two together.

Parameters:
none

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
irOp  in  4  IR[7:4], instruction opcode
di  in  5  DI register contents; di[4:3] selects the accumulator for memory-reference instructions
czn  in  3  flag register; czn[0]=C, czn[1]=Z, czn[2]=N
pcInc, pcLoadEn, diLoadEn, accumulatorWriteEn, memoryReadEn, memoryWriteEn, irWriteEn, trWriteEn, bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN  out  1 each  datapath strobes
PcOrTR  out  1  memory address select; 1=PC, 0=TR
regOrMem  out  1  B-register input; 0=memory, 1=accumulator
RegBOr0, RegAOr0  out  1 each  1 forces the corresponding ALU input to 0
accAddressSel  out  2  00=di[4:3], 01=IR[1:0], 10=IR[3:2]; 11 is never driven
aluOpControl  out  2  ALU operation; 00=ADD
instrDone  out  1  one-cycle pulse in the last cycle of every instruction
state  out  4  current state encoding, for debug only

Behaviour:
- Reset
  - rst=0 at a clock edge sets state to FETCH; this overrides any in-flight instruction.
  - While rst=0, all outputs are combinationally forced to 0.
- Default outputs: every output is 0 unless listed for the current state.
- Opcode map:
  - 0000 LDA, 0001 STA, 0010 JMP, 0011 JZ, 0100 JC, 0101 JN, 0110/0111 two-byte NOP.
  - 1000–1011 register ALU op, with aluOpControl = irOp[1:0].
  - 1100–1111 one-byte NOP.
- FETCH: memoryReadEn, PcOrTR=1, irWriteEn, pcInc → DECODE.
- DECODE, irOp[3]=0: memoryReadEn, PcOrTR=1, trWriteEn, diLoadEn, pcInc. Next state:
  - LDA → LDA1
  - STA → STA1
  - JMP/JZ/JC/JN → BR
  - 0110/0111 → FETCH with instrDone
- DECODE, irOp[3:2]=10: accAddressSel=01, aRegWriteEn → RDB.
- DECODE, irOp[3:2]=11: instrDone → FETCH.
- RDB: accAddressSel=10, regOrMem=1, bRegWriteEn → ALU.
- ALU: aluOpControl=irOp[1:0], aluResWriteEn, ldCZN → WB.
- WB: accAddressSel=10, accumulatorWriteEn, instrDone → FETCH.
- LDA1: PcOrTR=0, memoryReadEn, regOrMem=0, bRegWriteEn → LDA2.
- LDA2: RegAOr0=1, aluOpControl=00, aluResWriteEn; flags are not updated → LDA3.
- LDA3: accAddressSel=00, accumulatorWriteEn, instrDone → FETCH.
- STA1: accAddressSel=00, regOrMem=1, bRegWriteEn → STA2.
- STA2: RegAOr0=1, aluOpControl=00, aluResWriteEn → STA3.
- STA3: PcOrTR=0, memoryWriteEn, instrDone → FETCH.
- BR:
  - pcLoadEn = 1 for JMP, czn[1] for JZ, czn[0] for JC, czn[2] for JN.
  - Flags are sampled in the BR cycle itself.
  - instrDone asserted → FETCH.
- Latencies in cycles:
  - Register ALU, LDA, STA: 5.
  - JMP/Jcc taken or not taken: 3.
  - Two-byte NOP: 2.
  - One-byte NOP: 2.
- Mutual exclusion:
  - memoryReadEn and memoryWriteEn are never both 1.
  - pcInc and pcLoadEn are never both 1.
  - ldCZN is asserted only in ALU.
- Unused state encodings → FETCH on the next edge, with all outputs 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → all outputs 0 during reset; first cycle after release shows FETCH strobes (memoryReadEn=1, PcOrTR=1, irWriteEn=1, pcInc=1).
- LDA: irOp=0000, di=5'b10xxx → pcInc high in FETCH and DECODE; LDA1 PcOrTR=0; LDA3 accumulatorWriteEn=1 with accAddressSel=00; instrDone on cycle 5; ldCZN never 1.
- SUB: irOp=1001 → aRegWriteEn with sel 01, then bRegWriteEn with sel 10/regOrMem=1, then aluOpControl=01 with ldCZN=1, then accumulatorWriteEn with sel 10; 5 cycles total.
- JZ:
  - czn=3'b010 → pcLoadEn=1 in cycle 3.
  - czn=3'b000 → pcLoadEn=0, next cycle is FETCH.
  - Repeat for JC with czn[0] and JN with czn[2].
- STA interrupted: rst=0 during STA2 → memoryWriteEn never asserted; state=FETCH after release.
- NOPs:
  - irOp=1110 → instrDone in DECODE; back to FETCH on cycle 3.
  - irOp=0111 → trWriteEn=1 and pcInc=1 in DECODE; instrDone in the same cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore multi-cycle controller for the 8-bit accumulator CPU datapath.
// Ports: clk, rst (sync, active-low); status in: irOp, di, czn;
//   out: datapath strobes, mux selects, aluOpControl, instrDone, state.
module multicycle_control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] irOp,
   input  logic [4:0] di,
   input  logic [2:0] czn,
   output logic       pcInc,
   output logic       pcLoadEn,
   output logic       diLoadEn,
   output logic       accumulatorWriteEn,
   output logic       memoryReadEn,
   output logic       memoryWriteEn,
   output logic       irWriteEn,
   output logic       trWriteEn,
   output logic       bRegWriteEn,
   output logic       aRegWriteEn,
   output logic       aluResWriteEn,
   output logic       ldCZN,
   output logic       PcOrTR,
   output logic       regOrMem,
   output logic       RegBOr0,
   output logic       RegAOr0,
   output logic [1:0] accAddressSel,
   output logic [1:0] aluOpControl,
   output logic       instrDone,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      LDA1   = 4'd2,
      LDA2   = 4'd3,
      LDA3   = 4'd4,
      STA1   = 4'd5,
      STA2   = 4'd6,
      STA3   = 4'd7,
      BR     = 4'd8,
      RDB    = 4'd9,
      ALU    = 4'd10,
      WB     = 4'd11
   } state_t;

   state_t stateQ;
   state_t nextState;

   // di only steers the datapath accumulator mux, never the sequencing
   logic unusedDi;
   assign unusedDi = ^di;

   always_ff @(posedge clk) begin
      if (!rst) stateQ <= FETCH;
      else      stateQ <= nextState;
   end

   always_comb begin
      pcInc              = 1'b0;
      pcLoadEn           = 1'b0;
      diLoadEn           = 1'b0;
      accumulatorWriteEn = 1'b0;
      memoryReadEn       = 1'b0;
      memoryWriteEn      = 1'b0;
      irWriteEn          = 1'b0;
      trWriteEn          = 1'b0;
      bRegWriteEn        = 1'b0;
      aRegWriteEn        = 1'b0;
      aluResWriteEn      = 1'b0;
      ldCZN              = 1'b0;
      PcOrTR             = 1'b0;
      regOrMem           = 1'b0;
      RegBOr0            = 1'b0;
      RegAOr0            = 1'b0;
      accAddressSel      = 2'b00;
      aluOpControl       = 2'b00;
      instrDone          = 1'b0;
      state              = 4'd0;
      nextState          = FETCH;
      // reset masks every output, including the debug state
      if (rst) begin
         state = stateQ;
         unique case (stateQ)
            FETCH: begin
               memoryReadEn = 1'b1;
               PcOrTR       = 1'b1;
               irWriteEn    = 1'b1;
               pcInc        = 1'b1;
               nextState    = DECODE;
            end
            DECODE: begin
               unique case (1'b1)
                  !irOp[3]: begin
                     // second byte goes to both TR (address) and DI
                     memoryReadEn = 1'b1;
                     PcOrTR       = 1'b1;
                     trWriteEn    = 1'b1;
                     diLoadEn     = 1'b1;
                     pcInc        = 1'b1;
                     unique case (irOp[2:0])
                        3'b000:  nextState = LDA1;
                        3'b001:  nextState = STA1;
                        3'b010,
                        3'b011,
                        3'b100,
                        3'b101:  nextState = BR;
                        default: instrDone = 1'b1;
                     endcase
                  end
                  (irOp[3:2] == 2'b10): begin
                     accAddressSel = 2'b01;
                     aRegWriteEn   = 1'b1;
                     nextState     = RDB;
                  end
                  (irOp[3:2] == 2'b11): instrDone = 1'b1;
                  default: ;
               endcase
            end
            RDB: begin
               accAddressSel = 2'b10;
               regOrMem      = 1'b1;
               bRegWriteEn   = 1'b1;
               nextState     = ALU;
            end
            ALU: begin
               aluOpControl  = irOp[1:0];
               aluResWriteEn = 1'b1;
               ldCZN         = 1'b1;
               nextState     = WB;
            end
            WB: begin
               accAddressSel      = 2'b10;
               accumulatorWriteEn = 1'b1;
               instrDone          = 1'b1;
            end
            // LDA/STA pass the operand through the ALU as 0 + B
            LDA1: begin
               memoryReadEn = 1'b1;
               bRegWriteEn  = 1'b1;
               nextState    = LDA2;
            end
            LDA2: begin
               RegAOr0       = 1'b1;
               aluResWriteEn = 1'b1;
               nextState     = LDA3;
            end
            LDA3: begin
               accumulatorWriteEn = 1'b1;
               instrDone          = 1'b1;
            end
            STA1: begin
               regOrMem    = 1'b1;
               bRegWriteEn = 1'b1;
               nextState   = STA2;
            end
            STA2: begin
               RegAOr0       = 1'b1;
               aluResWriteEn = 1'b1;
               nextState     = STA3;
            end
            STA3: begin
               memoryWriteEn = 1'b1;
               instrDone     = 1'b1;
            end
            BR: begin
               instrDone = 1'b1;
               unique case (irOp[2:0])
                  3'b010:  pcLoadEn = 1'b1;
                  3'b011:  pcLoadEn = czn[1];
                  3'b100:  pcLoadEn = czn[0];
                  3'b101:  pcLoadEn = czn[2];
                  default: pcLoadEn = 1'b0;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Walks reset, LDA, STA, ALU ops, branches and NOPs cycle by cycle.
module tb_multicycle_control_unit;

   logic clk;
   logic rst;
   logic [3:0] irOp;
   logic [4:0] di;
   logic [2:0] czn;
   logic pcInc, pcLoadEn, diLoadEn, accumulatorWriteEn;
   logic memoryReadEn, memoryWriteEn, irWriteEn, trWriteEn;
   logic bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN;
   logic PcOrTR, regOrMem, RegBOr0, RegAOr0;
   logic [1:0] accAddressSel, aluOpControl;
   logic instrDone;
   logic [3:0] state;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic pcInc, pcLoadEn, diLoadEn, accWe;
      logic memRd, memWr, irWe, trWe;
      logic bWe, aWe, aluWe, ldCZN;
      logic pcOrTR, regOrMem, regBOr0, regAOr0;
      logic [1:0] accSel;
      logic [1:0] aluOp;
      logic done;
      logic [3:0] st;
   } ctl_t;

   ctl_t obs;
   assign obs = '{pcInc, pcLoadEn, diLoadEn, accumulatorWriteEn,
                  memoryReadEn, memoryWriteEn, irWriteEn, trWriteEn,
                  bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN,
                  PcOrTR, regOrMem, RegBOr0, RegAOr0,
                  accAddressSel, aluOpControl, instrDone, state};

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .irOp(irOp), .di(di), .czn(czn),
      .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn),
      .accumulatorWriteEn(accumulatorWriteEn),
      .memoryReadEn(memoryReadEn), .memoryWriteEn(memoryWriteEn),
      .irWriteEn(irWriteEn), .trWriteEn(trWriteEn),
      .bRegWriteEn(bRegWriteEn), .aRegWriteEn(aRegWriteEn),
      .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN),
      .PcOrTR(PcOrTR), .regOrMem(regOrMem),
      .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
      .accAddressSel(accAddressSel), .aluOpControl(aluOpControl),
      .instrDone(instrDone), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t eFetch();
      ctl_t e = '0;
      e.memRd = 1; e.pcOrTR = 1; e.irWe = 1; e.pcInc = 1;
      return e;
   endfunction

   function automatic ctl_t eDecM(input logic done);
      ctl_t e = '0;
      e.memRd = 1; e.pcOrTR = 1; e.trWe = 1;
      e.diLoadEn = 1; e.pcInc = 1; e.done = done; e.st = 4'd1;
      return e;
   endfunction

   function automatic ctl_t eDecA();
      ctl_t e = '0;
      e.accSel = 2'b01; e.aWe = 1; e.st = 4'd1;
      return e;
   endfunction

   function automatic ctl_t eDecN();
      ctl_t e = '0;
      e.done = 1; e.st = 4'd1;
      return e;
   endfunction

   function automatic ctl_t eRdb();
      ctl_t e = '0;
      e.accSel = 2'b10; e.regOrMem = 1; e.bWe = 1; e.st = 4'd9;
      return e;
   endfunction

   function automatic ctl_t eAlu(input logic [1:0] op);
      ctl_t e = '0;
      e.aluOp = op; e.aluWe = 1; e.ldCZN = 1; e.st = 4'd10;
      return e;
   endfunction

   function automatic ctl_t eWb();
      ctl_t e = '0;
      e.accSel = 2'b10; e.accWe = 1; e.done = 1; e.st = 4'd11;
      return e;
   endfunction

   function automatic ctl_t eLda(input int n);
      ctl_t e = '0;
      if (n == 1) begin e.memRd = 1; e.bWe = 1; e.st = 4'd2; end
      if (n == 2) begin e.regAOr0 = 1; e.aluWe = 1; e.st = 4'd3; end
      if (n == 3) begin e.accWe = 1; e.done = 1; e.st = 4'd4; end
      return e;
   endfunction

   function automatic ctl_t eSta(input int n);
      ctl_t e = '0;
      if (n == 1) begin e.regOrMem = 1; e.bWe = 1; e.st = 4'd5; end
      if (n == 2) begin e.regAOr0 = 1; e.aluWe = 1; e.st = 4'd6; end
      if (n == 3) begin e.memWr = 1; e.done = 1; e.st = 4'd7; end
      return e;
   endfunction

   function automatic ctl_t eBr(input logic taken);
      ctl_t e = '0;
      e.pcLoadEn = taken; e.done = 1; e.st = 4'd8;
      return e;
   endfunction

   task automatic cyc(input string tag, input ctl_t e);
      @(negedge clk);
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
      checks++;
      assert ({obs.memRd & obs.memWr, obs.pcInc & obs.pcLoadEn} === 2'b00)
      else begin
         failures++;
         $error("FAIL %s_excl observed=%b%b expected=00", tag,
                obs.memRd & obs.memWr, obs.pcInc & obs.pcLoadEn);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic branch(input string tag, input logic [3:0] op,
                         input logic [2:0] f, input logic taken);
      irOp = op;
      czn = f;
      cyc({tag, "_f"}, eFetch());
      cyc({tag, "_d"}, eDecM(1'b0));
      cyc({tag, "_br"}, eBr(taken));
   endtask

   initial begin
      rst = 1'b0;
      irOp = 4'b1010;
      di = 5'b00000;
      czn = 3'b111;
      @(posedge clk);
      #1;
      cyc("rst0", '0);
      cyc("rst1", '0);
      rst = 1'b1;

      irOp = 4'b0000;
      di = 5'b10101;
      czn = 3'b000;
      cyc("lda_f", eFetch());
      cyc("lda_d", eDecM(1'b0));
      cyc("lda_1", eLda(1));
      cyc("lda_2", eLda(2));
      cyc("lda_3", eLda(3));

      irOp = 4'b1001;
      cyc("sub_f", eFetch());
      cyc("sub_d", eDecA());
      cyc("sub_rdb", eRdb());
      cyc("sub_alu", eAlu(2'b01));
      cyc("sub_wb", eWb());

      irOp = 4'b1011;
      cyc("op3_f", eFetch());
      cyc("op3_d", eDecA());
      cyc("op3_rdb", eRdb());
      cyc("op3_alu", eAlu(2'b11));
      cyc("op3_wb", eWb());

      branch("jz_t", 4'b0011, 3'b010, 1'b1);
      branch("jz_n", 4'b0011, 3'b101, 1'b0);
      branch("jc_t", 4'b0100, 3'b001, 1'b1);
      branch("jc_n", 4'b0100, 3'b110, 1'b0);
      branch("jn_t", 4'b0101, 3'b100, 1'b1);
      branch("jn_n", 4'b0101, 3'b011, 1'b0);
      branch("jmp", 4'b0010, 3'b000, 1'b1);

      irOp = 4'b0001;
      di = 5'b01000;
      cyc("sti_f", eFetch());
      cyc("sti_d", eDecM(1'b0));
      cyc("sti_1", eSta(1));
      rst = 1'b0;
      cyc("sti_rst", '0);
      rst = 1'b1;
      cyc("sti_after", eFetch());
      cyc("sta_d", eDecM(1'b0));
      cyc("sta_1", eSta(1));
      cyc("sta_2", eSta(2));
      cyc("sta_3", eSta(3));

      irOp = 4'b1110;
      cyc("nop1_f", eFetch());
      cyc("nop1_d", eDecN());
      irOp = 4'b0111;
      cyc("nop2_f", eFetch());
      cyc("nop2_d", eDecM(1'b1));
      irOp = 4'b0110;
      cyc("nop2b_f", eFetch());
      cyc("nop2b_d", eDecM(1'b1));
      cyc("end_f", eFetch());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
